// File: rtl/ibex_pkg.sv
// Purpose: types and constants shared by the fetch realignment FIFO and its aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ibex_pkg;

  // One stored fetch response: the word as returned by memory plus its bus error.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

  // A halfword whose two LSBs are 2'b11 starts a 32-bit instruction.
  localparam logic [1:0] OPCODE_32B = 2'b11;

  function automatic logic is_32b(input logic [1:0] lsb);
    return lsb == OPCODE_32B;
  endfunction

endpackage

// File: rtl/ibex_fetch_realign_fifo_if.sv
// Purpose: bundle of the prefetcher-side, redirect and consumer-side signals of the fetch FIFO.
// Latency: n/a (wiring only).
// Backpressure: out_ready_i stalls the consumer side; busy_o throttles the prefetcher.
// Modports: slave = the FIFO itself, master = the prefetcher/decoder environment driving it.
interface ibex_fetch_realign_fifo_if;

  logic        clear_i;
  logic [31:0] clear_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        busy_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_is_compressed_o;
  logic        out_err_o;

  modport slave (
    input  clear_i, clear_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    output busy_o, out_valid_o, out_rdata_o, out_addr_o, out_is_compressed_o, out_err_o
  );

  modport master (
    output clear_i, clear_addr_i, in_valid_i, in_rdata_i, in_err_i, out_ready_i,
    input  busy_o, out_valid_o, out_rdata_o, out_addr_o, out_is_compressed_o, out_err_o
  );

endinterface

// File: rtl/ibex_fetch_aligner.sv
// Purpose: extract one 16/32-bit instruction from the two oldest fetch words at a halfword PC.
// Latency: purely combinational.
// Backpressure: none; reports whether consuming the instruction retires entry0 (pop).
// Ports: entry0/entry1 + valid0/valid1 = two oldest words, addr_hi = PC[1];
//        instr/is_compressed/err/valid = presented instruction, pop = entry0 retired on accept.
module ibex_fetch_aligner
  import ibex_pkg::*;
(
  input  fetch_entry_t entry0,
  input  fetch_entry_t entry1,
  input  logic         valid0,
  input  logic         valid1,
  input  logic         addr_hi,
  output logic [31:0]  instr,
  output logic         is_compressed,
  output logic         err,
  output logic         valid,
  output logic         pop
);

  // Only the low halfword of entry1 can ever be part of an instruction.
  logic unused_entry1_hi;
  assign unused_entry1_hi = ^entry1.rdata[31:16];

  always_comb begin
    instr         = '0;
    is_compressed = 1'b0;
    err           = 1'b0;
    valid         = 1'b0;
    pop           = 1'b0;

    if (valid0 && entry0.err) begin
      // A faulting word is handed over on its own so the error is taken at
      // this PC without waiting for a following word that may never arrive.
      valid = 1'b1;
      err   = 1'b1;
      pop   = 1'b1;
      instr = addr_hi ? {16'h0, entry0.rdata[31:16]} : entry0.rdata;
    end else if (!addr_hi) begin
      valid = valid0;
      if (is_32b(entry0.rdata[1:0])) begin
        instr = entry0.rdata;
        pop   = 1'b1;
      end else begin
        // Upper halfword still pending, so the word stays.
        instr         = {16'h0, entry0.rdata[15:0]};
        is_compressed = 1'b1;
      end
    end else if (!is_32b(entry0.rdata[17:16])) begin
      valid         = valid0;
      instr         = {16'h0, entry0.rdata[31:16]};
      is_compressed = 1'b1;
      pop           = 1'b1;
    end else begin
      // Straddling 32-bit instruction: needs the next word too.
      valid = valid0 & valid1;
      instr = {entry1.rdata[15:0], entry0.rdata[31:16]};
      err   = entry0.err | entry1.err;
      pop   = 1'b1;
    end

    // Nothing leaks out of stale/invalid storage.
    if (!valid) begin
      instr         = '0;
      is_compressed = 1'b0;
      err           = 1'b0;
      pop           = 1'b0;
    end
  end

endmodule

// File: rtl/ibex_fetch_realign_fifo.sv
// Purpose: fetch word buffer presenting one realigned instruction (16/32-bit) with its PC.
// Latency: 1 cycle in->out; 0 cycles when IBEX_FETCH_FIFO_BYPASS_EN is defined and the buffer is short.
// Backpressure: out_ready_i holds the instruction; busy_o rises at DEPTH-1 words so one in-flight response always fits.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport): clear_i/clear_addr_i redirect,
//        in_* fetch responses, busy_o, out_* realigned instruction handshake.
// Optional macro: IBEX_FETCH_FIFO_BYPASS_EN (input word feeds the aligner directly when the buffer is short).
// DEPTH legal range 2..8.
module ibex_fetch_realign_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  ibex_fetch_realign_fifo_if.slave bus
);

  fetch_entry_t [DEPTH-1:0] entry_q, entry_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [31:0]              addr_q, addr_d;

  fetch_entry_t             in_entry;
  logic                     push;
  logic [DEPTH:0]           vbase, ins_oh, ext_valid;
  fetch_entry_t [DEPTH:0]   ext_entry;

  fetch_entry_t             al_entry0, al_entry1;
  logic                     al_valid0, al_valid1;
  logic [31:0]              al_instr;
  logic                     al_comp, al_err, al_valid, al_pop;
  logic                     hs, pop, overflow;

  assign in_entry.rdata = bus.in_rdata_i;
  assign in_entry.err   = bus.in_err_i;

  // A response arriving with a redirect belongs to the old stream.
  assign push = bus.in_valid_i & ~bus.clear_i;

  // Storage plus the incoming word placed in the lowest free slot. Valid bits
  // are thermometer coded, so the lowest free slot is the first 0 above a 1.
  // Shifting this extended view by the pop count gives the next state, which
  // covers push, pop and push-with-pop uniformly.
  assign vbase     = {1'b0, valid_q};
  assign ins_oh    = {(DEPTH+1){push}} & ~vbase & {vbase[DEPTH-1:0], 1'b1};
  assign ext_valid = vbase | ins_oh;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ext_entry[i] = ins_oh[i] ? in_entry : entry_q[i];
    end
    ext_entry[DEPTH] = in_entry;
  end

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  // The aligner sees the incoming word as if already stored.
  assign al_entry0 = ext_entry[0];
  assign al_entry1 = ext_entry[1];
  assign al_valid0 = ext_valid[0];
  assign al_valid1 = ext_valid[1];
`else
  assign al_entry0 = entry_q[0];
  assign al_entry1 = entry_q[1];
  assign al_valid0 = valid_q[0];
  assign al_valid1 = valid_q[1];
`endif

  ibex_fetch_aligner u_aligner (
    .entry0        (al_entry0),
    .entry1        (al_entry1),
    .valid0        (al_valid0),
    .valid1        (al_valid1),
    .addr_hi       (addr_q[1]),
    .instr         (al_instr),
    .is_compressed (al_comp),
    .err           (al_err),
    .valid         (al_valid),
    .pop           (al_pop)
  );

  assign hs  = al_valid & bus.out_ready_i;
  // The consumer still sees a handshake during a redirect, but the flush wins.
  assign pop = hs & al_pop & ~bus.clear_i;

  // Full, pushing and not popping: the word has nowhere to go.
  assign overflow = ext_valid[DEPTH] & ~pop;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = pop ? ext_entry[i+1] : ext_entry[i];
      valid_d[i] = pop ? ext_valid[i+1] : ext_valid[i];
    end
    addr_d = addr_q;
    if (bus.clear_i) begin
      valid_d = '0;
      addr_d  = bus.clear_addr_i;
    end else if (hs) begin
      addr_d = addr_q + (al_comp ? 32'd2 : 32'd4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  // Thermometer valid bits: count >= DEPTH-1 exactly when slot DEPTH-2 is full.
  assign bus.busy_o              = valid_q[DEPTH-2];
  assign bus.out_valid_o         = al_valid;
  assign bus.out_rdata_o         = al_instr;
  assign bus.out_addr_o          = addr_q;
  assign bus.out_is_compressed_o = al_comp;
  assign bus.out_err_o           = al_err;

  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow);

endmodule
